// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Control FSM for a multi-cycle core. It steps each instruction
//               through FETCH, DECODE, EXEC, an optional MEM and WB over
//               handshaked instruction/data memories. It drives IR capture,
//               the gated register-file write and the PC update. It also keeps
//               a retired-instruction counter and latches a sticky error when
//               a memory handshake times out.
// Ports       : clk             rising-edge clock
//               rst             asynchronous active-high reset
//               i_run           1 = execute (sampled in IDLE and WB)
//               i_imem_ack      instruction memory acknowledge
//               i_dmem_ack      data memory acknowledge
//               i_dec_load      decoded load
//               i_dec_store     decoded store
//               i_dec_reg_write decoded register write enable
//               o_imem_req      fetch request
//               o_ir_we         capture instruction into IR
//               o_dmem_req      data request
//               o_dmem_we       data request is a write
//               o_reg_we        register-file write enable (gated)
//               o_pc_we         PC update strobe
//               o_busy          sequencer not idle
//               o_error         sticky handshake timeout flag
//               o_instret       retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_imem_ack,
   input  logic             i_dmem_ack,
   input  logic             i_dec_load,
   input  logic             i_dec_store,
   input  logic             i_dec_reg_write,
   output logic             o_imem_req,
   output logic             o_ir_we,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic             o_reg_we,
   output logic             o_pc_we,
   output logic             o_busy,
   output logic             o_error,
   output logic [CNT_W-1:0] o_instret
);

   // Wait counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int c_WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WAIT_W-1:0] r_wait_cnt;
   logic [c_WAIT_W-1:0] w_wait_nxt;
   logic [CNT_W-1:0]    r_instret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_instret  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (r_state == S_WB) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // The wait counter defaults to zero, so it is already clear on every
   // entry to FETCH or MEM; it only advances while a handshake is pending.
   // An ack in the timeout cycle is tested first, so the ack wins the tie.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = '0;
      o_imem_req  = 1'b0;
      o_ir_we     = 1'b0;
      o_dmem_req  = 1'b0;
      o_dmem_we   = 1'b0;
      o_reg_we    = 1'b0;
      o_pc_we     = 1'b0;
      o_busy      = (r_state != S_IDLE);
      o_error     = (r_state == S_ERR);

      case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ack) begin
               o_ir_we     = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt = S_ERR;
            end else begin
               w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
            end
         end
         S_DECODE: begin
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = (i_dec_load | i_dec_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = i_dec_store;
            if (i_dmem_ack) begin
               w_state_nxt = S_WB;
            end else if (r_wait_cnt == c_WAIT_LAST) begin
               w_state_nxt = S_ERR;
            end else begin
               w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
            end
         end
         S_WB: begin
            o_pc_we     = 1'b1;
            // Stores never write the register file even if decode asks to.
            o_reg_we    = i_dec_reg_write & ~i_dec_store;
            w_state_nxt = i_run ? S_FETCH : S_IDLE;
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_instret = r_instret;

endmodule
`default_nettype wire
